// File: rtl/frame_bit_timer.sv
// rtl/frame_bit_timer.sv - programmable bit-period timer with mid-bit tick and frame-end flag
// Continuous or one-shot frames of FRAME_BITS bit ticks, each DIV enabled clocks long.
module frame_bit_timer #(
  parameter int WIDTH      = 8,
  parameter int FRAME_BITS = 10,
  parameter int BWIDTH     = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic              START,
  input  logic              STOP,
  input  logic              ONESHOT,
  input  logic [WIDTH-1:0]  DIV,
  output logic              Semnal,
  output logic              HALF,
  output logic              DONE,
  output logic              BUSY,
  output logic [BWIDTH-1:0] BITIDX
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] divl;
  logic [WIDTH-1:0] half_at;
  logic             wrap;
  logic             last_bit;

  // Mid-bit point; periods of 0 or 1 put it on the same edge as the wrap.
  always_comb begin
    half_at = '0;
    if (divl >= WIDTH'(2))
      half_at = (divl >> 1) - WIDTH'(1);
  end

  assign wrap     = (cnt == divl - WIDTH'(1));
  assign last_bit = (BITIDX == BWIDTH'(FRAME_BITS - 1));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      cnt    <= '0;
      divl   <= WIDTH'(1);
      BITIDX <= '0;
      Semnal <= 1'b0;
      HALF   <= 1'b0;
      DONE   <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      Semnal <= 1'b0;
      HALF   <= 1'b0;
      DONE   <= 1'b0;
      if (STOP) begin
        state  <= IDLE;
        cnt    <= '0;
        BITIDX <= '0;
        BUSY   <= 1'b0;
      end else if (START) begin
        state  <= RUN;
        cnt    <= '0;
        BITIDX <= '0;
        divl   <= (DIV == '0) ? WIDTH'(1) : DIV;
        BUSY   <= 1'b1;
      end else if (state == RUN && CE) begin
        if (cnt == half_at)
          HALF <= 1'b1;
        if (wrap) begin
          cnt    <= '0;
          Semnal <= 1'b1;
          if (last_bit) begin
            DONE   <= 1'b1;
            BITIDX <= '0;
            if (ONESHOT) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            BITIDX <= BITIDX + BWIDTH'(1);
          end
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: doc/frame_bit_timer.md
Name: frame_bit_timer

Overview:
Parametrised bit-period timer for the serial transmission path. It divides CLK by a programmable period DIV to produce a bit tick, plus a mid-bit tick used by the receiver for sampling. It also counts ticks per frame and flags the frame end. It runs in continuous or one-shot mode and supersedes the fixed divide-by-10 enable counter.

Parameters:
WIDTH, 8, width of period divider and DIV input.
FRAME_BITS, 10, bit ticks per frame (>=1).
BWIDTH, 4, width of bit index; must satisfy 2^BWIDTH >= FRAME_BITS.

Ports:
CLK  in  1  system clock, rising edge.
CLR  in  1  asynchronous active-high reset.
CE  in  1  clock enable; counters advance only on edges with CE=1.
START  in  1  start or restart the timer (sampled on CLK).
STOP  in  1  return to idle (sampled on CLK).
ONESHOT  in  1  mode: 1 = stop after one frame, 0 = continuous frames.
DIV  in  WIDTH  bit period in enabled clocks; latched on START.
Semnal  out  1  bit tick, one-cycle pulse.
HALF  out  1  mid-bit tick, one-cycle pulse.
DONE  out  1  frame-end pulse, coincident with the last Semnal of a frame.
BUSY  out  1  high while in RUN.
BITIDX  out  BWIDTH  index of the current bit in the frame, 0..FRAME_BITS-1.

Behaviour:
- States: IDLE, RUN. All outputs are registered.
- Reset (CLR=1, async): state IDLE; internal count cnt=0; BITIDX=0; latched period DIVL=1; Semnal, HALF, DONE, BUSY = 0. Outputs stay at these values while CLR is high. First action is taken on the first edge after CLR falls.
- Pulses default low every edge. They are high only in the cycle after a qualifying edge.
- Priority per edge: CLR > STOP > START > counting.
- STOP=1: go to IDLE, clear cnt and BITIDX, no pulses. STOP wins over a simultaneous START. STOP in IDLE has no effect.
- START=1 (either state, STOP=0): go to RUN, cnt=0, BITIDX=0, DIVL=DIV (DIV=0 is latched as 1). No pulse on this edge. START in RUN is a restart and discards any pending wrap.
- START and STOP act regardless of CE. Counting requires CE=1.
- RUN, CE=1:
  - If cnt==DIVL-1: cnt wraps to 0 and Semnal=1 next cycle.
  - Otherwise cnt increments.
  - If cnt==HALF_AT: HALF=1 next cycle, where HALF_AT = (DIVL>>1)-1, or 0 when DIVL<2. With DIVL=1, HALF and Semnal fire together every enabled edge.
- On each wrap:
  - If BITIDX==FRAME_BITS-1: DONE=1 and BITIDX=0.
    - ONESHOT=1 (sampled on that edge): go to IDLE, cnt=0, BUSY falls next cycle.
    - ONESHOT=0: stay in RUN.
  - Otherwise BITIDX increments.
- RUN, CE=0: all counters hold, no pulses.
- IDLE: counters held at 0, CE ignored.
- Latency: first Semnal is high in the cycle after the DIVL-th enabled edge following the START edge. First HALF follows the (HALF_AT+1)-th enabled edge.
- DIV changes while in RUN have no effect until the next START.
- BUSY = (state==RUN), registered. It rises on the cycle after the START edge.

Test Plan:
- Reset: assert CLR mid-run with DIV=10 -> all outputs 0 immediately (asynchronously). After release with no START, nothing toggles for 50 cycles.
- Continuous, DIV=10, FRAME_BITS=10, CE=1, single-cycle START -> Semnal every 10 cycles (first after the 10th edge post-START). HALF 5 cycles after START, then every 10 cycles. DONE together with the 10th Semnal. BITIDX cycles 0..9. BUSY stays high.
- One-shot, DIV=4, ONESHOT=1 -> exactly 10 Semnal pulses, DONE on the last one, BUSY low from the cycle after DONE. No further pulses over 100 cycles.
- CE gating, DIV=6: CE high every 2nd cycle -> Semnal every 12 CLK cycles. Hold CE low for 20 cycles mid-bit -> cnt and BITIDX frozen, no pulses.
- Boundaries: DIV=0 and DIV=1 -> Semnal and HALF together on every enabled edge. DIV=255 -> Semnal period 255. START and STOP on the same edge in RUN -> IDLE.
- Restart: START at BITIDX=5, cnt=3, with new DIV=8 -> BITIDX=0, next Semnal 8 enabled edges later, no DONE for the aborted frame.
